// File: rtl/ws2812_chain_driver.sv
// WS2812B chain driver: streams NUM_LEDS pixels from a valid/ready source onto the LED data line.
// Optional WS2812_AUTOFRAME_EN: after each latch period the driver re-enters FETCH without start.
module ws2812_chain_driver #(
  parameter int NUM_LEDS     = 64,
  parameter int BITS_PER_LED = 24,
  parameter int T0H_CYC      = 16,
  parameter int T0L_CYC      = 34,
  parameter int T1H_CYC      = 32,
  parameter int T1L_CYC      = 18,
  parameter int RESET_CYC    = 2000,
  localparam int IDX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BITS_PER_LED-1:0] pix_data,
  input  logic                    pix_valid,
  output logic                    pix_ready,
  output logic [IDX_W-1:0]        pix_idx,
  output logic                    datastream,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    underrun
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_T = max2(max2(max2(T0H_CYC, T0L_CYC), max2(T1H_CYC, T1L_CYC)), RESET_CYC);
  localparam int PH_W  = $clog2(MAX_T + 1);
  localparam int BIT_W = (BITS_PER_LED > 1) ? $clog2(BITS_PER_LED) : 1;

  localparam logic [PH_W-1:0]  T0H_LAST   = PH_W'(T0H_CYC - 1);
  localparam logic [PH_W-1:0]  T0L_LAST   = PH_W'(T0L_CYC - 1);
  localparam logic [PH_W-1:0]  T1H_LAST   = PH_W'(T1H_CYC - 1);
  localparam logic [PH_W-1:0]  T1L_LAST   = PH_W'(T1L_CYC - 1);
  localparam logic [PH_W-1:0]  RESET_LAST = PH_W'(RESET_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_TOP    = BIT_W'(BITS_PER_LED - 1);
  localparam logic [IDX_W-1:0] LED_LAST   = IDX_W'(NUM_LEDS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HIGH  = 3'd2;
  localparam logic [2:0] S_LOW   = 3'd3;
  localparam logic [2:0] S_LATCH = 3'd4;

  logic [2:0]              state_q, state_d;
  logic [PH_W-1:0]         phase_q, phase_d;
  logic [BIT_W-1:0]        bitcnt_q, bitcnt_d;
  logic [IDX_W-1:0]        ledcnt_q, ledcnt_d;
  logic [IDX_W-1:0]        pix_idx_q, pix_idx_d;
  logic [BITS_PER_LED-1:0] shift_q, shift_d;
  logic [BITS_PER_LED-1:0] hold_q, hold_d;
  logic                    hold_full_q, hold_full_d;
  logic                    datastream_q, datastream_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic                    underrun_q, underrun_d;

  logic                    accept;
  logic                    bypass;
  logic [PH_W-1:0]         high_last;
  logic [PH_W-1:0]         low_last;

  // Prefetch is offered only while a later pixel of this frame still has to be fetched.
  assign pix_ready = (state_q == S_FETCH) ||
                     (((state_q == S_HIGH) || (state_q == S_LOW)) &&
                      !hold_full_q && (ledcnt_q != LED_LAST));
  assign accept    = pix_valid && pix_ready;
  assign high_last = shift_q[BITS_PER_LED-1] ? T1H_LAST : T0H_LAST;
  assign low_last  = shift_q[BITS_PER_LED-1] ? T1L_LAST : T0L_LAST;

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bitcnt_d     = bitcnt_q;
    ledcnt_d     = ledcnt_q;
    pix_idx_d    = pix_idx_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_full_d  = hold_full_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    bypass       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FETCH;
          pix_idx_d   = '0;
          hold_full_d = 1'b0;
        end
      end
      S_FETCH: begin
        if (accept) begin
          shift_d  = pix_data;
          bitcnt_d = BIT_TOP;
          ledcnt_d = '0;
          phase_d  = '0;
          state_d  = S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_q == high_last) begin
          phase_d = '0;
          state_d = S_LOW;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LOW: begin
        if (phase_q == low_last) begin
          phase_d = '0;
          if (bitcnt_q != '0) begin
            shift_d  = shift_q << 1;
            bitcnt_d = bitcnt_q - 1'b1;
            state_d  = S_HIGH;
          end else if (ledcnt_q == LED_LAST) begin
            state_d = S_LATCH;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            bitcnt_d    = BIT_TOP;
            ledcnt_d    = ledcnt_q + 1'b1;
            state_d     = S_HIGH;
          end else if (accept) begin
            // A pixel arriving on the very last low cycle goes straight to the shifter.
            bypass   = 1'b1;
            shift_d  = pix_data;
            bitcnt_d = BIT_TOP;
            ledcnt_d = ledcnt_q + 1'b1;
            state_d  = S_HIGH;
          end else begin
            underrun_d = 1'b1;
            state_d    = S_LATCH;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      S_LATCH: begin
        if (phase_q == RESET_LAST) begin
          phase_d      = '0;
          frame_done_d = 1'b1;
`ifdef WS2812_AUTOFRAME_EN
          state_d      = S_FETCH;
          pix_idx_d    = '0;
          hold_full_d  = 1'b0;
`else
          state_d      = S_IDLE;
`endif
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = '0;
      end
    endcase

    // Capture lands after any transfer above, so a same-cycle accept is never lost.
    if (accept && (state_q != S_FETCH) && !bypass) begin
      hold_d      = pix_data;
      hold_full_d = 1'b1;
    end
    if (accept) begin
      pix_idx_d = pix_idx_q + 1'b1;
    end

    datastream_d = (state_d == S_HIGH);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      phase_q      <= '0;
      bitcnt_q     <= '0;
      ledcnt_q     <= '0;
      pix_idx_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      datastream_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bitcnt_q     <= bitcnt_d;
      ledcnt_q     <= ledcnt_d;
      pix_idx_q    <= pix_idx_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      datastream_q <= datastream_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  assign pix_idx    = pix_idx_q;
  assign datastream = datastream_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: random pixel frames compared against a waveform built from the bit timing rules.
module tb_ws2812_chain_driver;
  localparam int NUM_LEDS = 3;
  localparam int BPL      = 24;
  localparam int T0H      = 16;
  localparam int T0L      = 34;
  localparam int T1H      = 32;
  localparam int T1L      = 18;
  localparam int RST      = 2000;
  localparam int IDX_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
`ifdef WS2812_AUTOFRAME_EN
  localparam bit POST_BUSY = 1'b1;
`else
  localparam bit POST_BUSY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [BPL-1:0]   pix_data = '0;
  logic             pix_valid = 1'b0;
  logic             pix_ready;
  logic [IDX_W-1:0] pix_idx;
  logic             datastream;
  logic             busy;
  logic             frame_done;
  logic             underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ws2812_chain_driver #(
    .NUM_LEDS(NUM_LEDS), .BITS_PER_LED(BPL),
    .T0H_CYC(T0H), .T0L_CYC(T0L), .T1H_CYC(T1H), .T1L_CYC(T1L), .RESET_CYC(RST)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_idx(pix_idx),
    .datastream(datastream), .busy(busy), .frame_done(frame_done), .underrun(underrun)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One frame: offer n_supply pixels, capture the line from its first high cycle and compare.
  task automatic run_frame(input string name, input int n_supply, input bit send_start,
                           input bit fixed_first, input int start_at_bit, input int reset_at_bit);
    logic [BPL-1:0] px [8];
    logic exp_q [$];
    int k, stream_len, sent, t, highs, mism, busy_bad, idle_bad, fd_cnt, fd_at, ur_cnt, ur_at;
    int h, l;
    bit prev_ds, done, aborted, start_now, start_injected;
    sent = 0; t = -1; highs = 0; mism = 0; busy_bad = 0; idle_bad = 0;
    fd_cnt = 0; fd_at = -1; ur_cnt = 0; ur_at = -1;
    prev_ds = 1'b0; done = 1'b0; aborted = 1'b0; start_injected = 1'b0;
    for (int i = 0; i < 8; i++) px[i] = BPL'($urandom);
    if (fixed_first) px[0] = 24'h800000;
    k = (n_supply < NUM_LEDS) ? n_supply : NUM_LEDS;
    for (int i = 0; i < k; i++) begin
      for (int b = BPL - 1; b >= 0; b--) begin
        h = px[i][b] ? T1H : T0H;
        l = px[i][b] ? T1L : T0L;
        repeat (h) exp_q.push_back(1'b1);
        repeat (l) exp_q.push_back(1'b0);
      end
    end
    stream_len = exp_q.size();
    repeat (RST) exp_q.push_back(1'b0);
    start_now = send_start;

    for (int cyc = 0; cyc < 12000 && !done; cyc++) begin
      start = start_now;
      start_now = 1'b0;
      if (sent < n_supply) begin
        pix_valid = 1'b1;
        pix_data  = px[sent];
      end else begin
        pix_valid = 1'b0;
        pix_data  = '0;
      end
      @(negedge clk);
      if (pix_valid && pix_ready) begin
        check({name, "/pix_idx"}, pix_idx, sent);
        sent++;
      end
      if (t < 0 && datastream === 1'b1) t = 0;
      if (t >= 0) begin
        if (t < exp_q.size()) begin
          if (datastream !== exp_q[t]) mism++;
          if (busy !== 1'b1) busy_bad++;
        end else if (busy !== POST_BUSY || (!POST_BUSY && pix_ready !== 1'b0)) begin
          idle_bad++;
        end
        if (datastream === 1'b1 && prev_ds !== 1'b1) highs++;
        if (frame_done === 1'b1) begin fd_cnt++; fd_at = t; end
        if (underrun === 1'b1) begin ur_cnt++; ur_at = t; end
        t++;
        if (t >= exp_q.size() + 4) done = 1'b1;
      end
      prev_ds = datastream;
      if (start_at_bit >= 0 && !start_injected && highs == start_at_bit + 1 && datastream === 1'b1) begin
        start_now = 1'b1;
        start_injected = 1'b1;
      end
      if (reset_at_bit >= 0 && t >= 0 && highs == reset_at_bit + 1 && datastream === 1'b0) begin
        @(posedge clk); #1;
        reset = 1'b0; pix_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check({name, "/reset_datastream"}, datastream, 0);
        check({name, "/reset_busy"}, busy, 0);
        check({name, "/reset_pix_ready"}, pix_ready, 0);
        aborted = 1'b1;
        done = 1'b1;
      end
      if (!done) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    pix_valid = 1'b0;

    if (reset_at_bit >= 0) check({name, "/reset_hit"}, aborted, 1);
    if (!aborted) begin
      check({name, "/frame_seen"}, done, 1);
      check({name, "/waveform_bad_cycles"}, mism, 0);
      check({name, "/busy_low_in_frame"}, busy_bad, 0);
      check({name, "/post_frame_state"}, idle_bad, 0);
      check({name, "/high_pulses"}, highs, BPL * k);
      check({name, "/accepted"}, sent, k);
      check({name, "/frame_done_count"}, fd_cnt, 1);
      check({name, "/frame_done_at"}, fd_at, exp_q.size());
      check({name, "/underrun_count"}, ur_cnt, (k < NUM_LEDS) ? 1 : 0);
      if (k < NUM_LEDS) check({name, "/underrun_at"}, ur_at, stream_len);
    end
    $display("frame %s: accepted=%0d highs=%0d frame_done@%0d underruns=%0d aborted=%0d",
             name, sent, highs, fd_at, ur_cnt, aborted);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst/datastream", datastream, 0);
    check("rst/busy", busy, 0);
    check("rst/pix_ready", pix_ready, 0);
    check("rst/frame_done", frame_done, 0);
    check("rst/underrun", underrun, 0);
    check("rst/pix_idx", pix_idx, 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Pixels offered while idle are not taken and nothing starts.
    pix_valid = 1'b1;
    pix_data  = 24'hABCDEF;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("idle/pix_ready", pix_ready, 0);
    check("idle/busy", busy, 0);
    @(posedge clk); #1;
    pix_valid = 1'b0;

`ifdef WS2812_AUTOFRAME_EN
    run_frame("auto_first", NUM_LEDS, 1'b1, 1'b0, -1, -1);
    run_frame("auto_second", NUM_LEDS, 1'b0, 1'b0, -1, -1);
    pulse_reset();
`endif

    run_frame("msb_only_first", NUM_LEDS, 1'b1, 1'b1, -1, -1);
    if (POST_BUSY) pulse_reset();
    run_frame("random_a", NUM_LEDS, 1'b1, 1'b0, -1, -1);
    if (POST_BUSY) pulse_reset();
    run_frame("random_b", NUM_LEDS, 1'b1, 1'b0, -1, -1);
    if (POST_BUSY) pulse_reset();
    run_frame("underrun", 1, 1'b1, 1'b0, -1, -1);
    if (POST_BUSY) pulse_reset();
    run_frame("start_in_high", NUM_LEDS, 1'b1, 1'b0, 10, -1);
    if (POST_BUSY) pulse_reset();
    run_frame("reset_in_low", NUM_LEDS, 1'b1, 1'b0, -1, 5);
    run_frame("after_reset", NUM_LEDS, 1'b1, 1'b0, -1, -1);
    if (POST_BUSY) pulse_reset();
    run_frame("oversupply", NUM_LEDS + 2, 1'b1, 1'b0, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
